// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back entry type used by the write-back queue.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W        = 5;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned WBQ_DEPTH_DEFAULT = 4;

  // Field "reg" is a reserved word, so the destination index is named rd.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bundle of the write-back queue's offer, register-file write and forwarding signals.
interface wb_queue_if #(
  parameter int unsigned DEPTH = cpu_pkg::WBQ_DEPTH_DEFAULT
);
  import cpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;

  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;

  logic [REG_ADDR_W-1:0] q_reg1;
  logic [REG_ADDR_W-1:0] q_reg2;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_W-1:0]     fwd_data1;
  logic [DATA_W-1:0]     fwd_data2;

  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, q_reg1, q_reg2,
    input  alu_ready, mem_ready, write_enable, write_reg, write_data,
    input  hit1, hit2, fwd_data1, fwd_data2, count, full, empty
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, q_reg1, q_reg2,
    output alu_ready, mem_ready, write_enable, write_reg, write_data,
    output hit1, hit2, fwd_data1, fwd_data2, count, full, empty
  );

endinterface

// File: rtl/wbq_lookup.sv
// Newest-match search over the occupied entries of the write-back queue.
module wbq_lookup
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH_DEFAULT
) (
  input  wb_entry_t [DEPTH-1:0]        i_entries,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [$clog2(DEPTH):0]       i_count,
  input  logic [REG_ADDR_W-1:0]        i_q_reg,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so the last match wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if ((CNT_W'(i) < i_count) && (i_q_reg != '0) && (i_entries[w_idx].rd == i_q_reg)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results into one register-file write per cycle,
// with operand forwarding from pending entries.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  wb_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_pop;
  logic [CNT_W-1:0]      w_free;
  logic                  w_alu_store;
  logic                  w_mem_store;
  logic [PTR_W-1:0]      w_mem_slot;
  wb_entry_t             w_head_entry;

  assign w_pop  = (r_count != '0);
  // The head leaves this cycle, so its slot is already available to new offers.
  assign w_free = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);

  assign bus.alu_ready = (w_free >= CNT_W'(1));
  assign bus.mem_ready = bus.alu_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));

  // Register 0 writes are acknowledged but never stored.
  assign w_alu_store = !rst && bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);
  assign w_mem_store = !rst && bus.mem_valid && bus.mem_ready && (bus.mem_reg != '0);
  assign w_mem_slot  = r_tail + PTR_W'(w_alu_store);

  always_ff @(posedge clk) begin
    if (w_alu_store) begin
      r_entries[r_tail] <= '{rd: bus.alu_reg, data: bus.alu_data};
    end
    if (w_mem_store) begin
      r_entries[w_mem_slot] <= '{rd: bus.mem_reg, data: bus.mem_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_alu_store) + PTR_W'(w_mem_store);
      r_count <= r_count + CNT_W'(w_alu_store) + CNT_W'(w_mem_store) - CNT_W'(w_pop);
    end
  end

  assign w_head_entry     = r_entries[r_head];
  assign bus.write_enable = w_pop;
  assign bus.write_reg    = w_pop ? w_head_entry.rd : '0;
  assign bus.write_data   = w_pop ? w_head_entry.data : '0;

  assign bus.count = r_count;
  assign bus.full  = (r_count == CNT_W'(DEPTH));
  assign bus.empty = !w_pop;

  wbq_lookup #(
    .DEPTH (DEPTH)
  ) u_lookup1 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_q_reg   (bus.q_reg1),
    .o_hit     (bus.hit1),
    .o_data    (bus.fwd_data1)
  );

  wbq_lookup #(
    .DEPTH (DEPTH)
  ) u_lookup2 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_q_reg   (bus.q_reg2),
    .o_hit     (bus.hit2),
    .o_data    (bus.fwd_data2)
  );

endmodule
